// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the PWM bank: mode encoding and time-base phase.
package pwm_bank_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        PHASE_UP   = 1'b0,
        PHASE_DOWN = 1'b1
    } phase_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM time base: up or up/down counter with period start/end decode.
module pwm_timebase
    import pwm_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mode,
    output logic [WIDTH-1:0] counter,
    output logic             period_start,
    output logic             period_end
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] count_reg, count_next;
    phase_e           phase_reg, phase_next;
    logic             running_reg;

    // The counter holds at zero until the first edge after reset, so that
    // edge opens the first period.
    always_comb begin
        count_next = count_reg;
        phase_next = phase_reg;
        period_end = 1'b0;
        if (running_reg) begin
            if (mode == MODE_CENTER) begin
                if (phase_reg == PHASE_UP) begin
                    if (count_reg == CNT_MAX) begin
                        phase_next = PHASE_DOWN;
                    end else begin
                        count_next = count_reg + WIDTH'(1);
                    end
                end else if (count_reg == '0) begin
                    period_end = 1'b1;
                    phase_next = PHASE_UP;
                end else begin
                    count_next = count_reg - WIDTH'(1);
                end
            end else begin
                count_next = count_reg + WIDTH'(1);
                phase_next = PHASE_UP;
                period_end = (count_reg == CNT_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg   <= '0;
            phase_reg   <= PHASE_UP;
            running_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            phase_reg   <= phase_next;
            running_reg <= 1'b1;
        end
    end

    assign counter      = count_reg;
    assign period_start = running_reg && (phase_reg == PHASE_UP) && (count_reg == '0);

endmodule

// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing one time base, with shadowed levels and mode
// that are transferred to the active copies only at a period boundary.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int                  CHANNELS = 3,
    parameter int                  WIDTH    = 8,
    parameter logic [CHANNELS-1:0] INVERT   = '0,
    localparam int                 CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CHAN_W-1:0]   wr_chan,
    input  logic [WIDTH:0]      wr_level,
    input  logic                mode_in,
    input  logic                commit,
    output logic                pending,
    output logic                period_start,
    output logic [CHANNELS-1:0] out
);

    logic             pending_reg;
    logic             mode_shadow_reg;
    logic             mode_active_reg;
    logic [WIDTH-1:0] counter;
    logic             period_end;
    logic             wr_accept;
    logic             commit_accept;
    logic             transfer;

    assign wr_ready      = !pending_reg;
    assign pending       = pending_reg;
    assign wr_accept     = wr_valid && !pending_reg;
    assign commit_accept = commit && !pending_reg;
    assign transfer      = period_end && pending_reg;

    pwm_timebase #(
        .WIDTH(WIDTH)
    ) u_timebase (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode         (mode_active_reg),
        .counter      (counter),
        .period_start (period_start),
        .period_end   (period_end)
    );

    // A commit landing in the boundary cycle only sets pending; the transfer
    // branch needs pending already high, so it waits one more period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg     <= 1'b0;
            mode_shadow_reg <= MODE_EDGE;
            mode_active_reg <= MODE_EDGE;
        end else if (transfer) begin
            pending_reg     <= 1'b0;
            mode_active_reg <= mode_shadow_reg;
        end else if (commit_accept) begin
            pending_reg     <= 1'b1;
            mode_shadow_reg <= mode_in;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH:0] shadow_level_reg;
            logic [WIDTH:0] active_level_reg;
            logic           out_reg;

            // Out-of-range channel numbers match no channel and are dropped.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_level_reg <= '0;
                    active_level_reg <= '0;
                    out_reg          <= INVERT[gi];
                end else begin
                    if (wr_accept && (wr_chan == CHAN_W'(gi))) begin
                        shadow_level_reg <= wr_level;
                    end
                    if (transfer) begin
                        active_level_reg <= shadow_level_reg;
                    end
                    out_reg <= ({1'b0, counter} < active_level_reg) ^ INVERT[gi];
                end
            end

            assign out[gi] = out_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_bank.sv
// Randomized and directed bench for pwm_bank against a period-position model.
module tb_pwm_bank;

    localparam int              CH  = 3;
    localparam int              W   = 4;
    localparam int              N   = 1 << W;
    localparam logic [CH-1:0]   INV = 3'b010;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [1:0]    wr_chan;
    logic [W:0]    wr_level;
    logic          mode_in;
    logic          commit;
    logic          pending;
    logic          period_start;
    logic [CH-1:0] out;

    pwm_bank #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .INVERT   (INV)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_chan      (wr_chan),
        .wr_level     (wr_level),
        .mode_in      (mode_in),
        .commit       (commit),
        .pending      (pending),
        .period_start (period_start),
        .out          (out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: position within the current period rather than a counter.
    int            m_t;
    bit            m_run;
    bit            m_pending;
    bit            m_mode;
    bit            m_mode_sh;
    int            m_sh  [CH];
    int            m_act [CH];
    logic [CH-1:0] m_out;

    int act_cnt [CH];
    int raw_cnt [CH];
    int ps_cnt;
    int n_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int plen(input bit md);
        return md ? 2 * N : N;
    endfunction

    function automatic int cnt_of(input int t, input bit md);
        if (!md) return t;
        return (t < N) ? t : (2 * N - 1 - t);
    endfunction

    task automatic model_reset();
        m_t = 0; m_run = 0; m_pending = 0; m_mode = 0; m_mode_sh = 0;
        for (int i = 0; i < CH; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        m_out = INV;
    endtask

    task automatic model_edge();
        int cnt;
        bit last;
        cnt  = cnt_of(m_t, m_mode);
        last = m_run && (m_t == plen(m_mode) - 1);
        for (int i = 0; i < CH; i++) begin
            m_out[i] = ((cnt < m_act[i]) ? 1'b1 : 1'b0) ^ INV[i];
        end
        if (wr_valid && !m_pending && (int'(wr_chan) < CH)) m_sh[wr_chan] = int'(wr_level);
        if (last && m_pending) begin
            for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
            m_mode    = m_mode_sh;
            m_pending = 0;
            $display("txn transfer mode=%0d levels=%0d/%0d/%0d", m_mode, m_act[0], m_act[1], m_act[2]);
        end else if (commit && !m_pending) begin
            m_pending = 1;
            m_mode_sh = mode_in;
            $display("txn commit mode=%0d", mode_in);
        end
        if (!m_run) begin
            m_run = 1;
            m_t   = 0;
        end else if (last) begin
            m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic step(input logic v, input logic [1:0] ch, input logic [W:0] lv,
                        input logic md, input logic cm);
        wr_valid = v; wr_chan = ch; wr_level = lv; mode_in = md; commit = cm;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("out", out, m_out);
        check("pending", pending, m_pending);
        check("wr_ready", wr_ready, !m_pending);
        check("period_start", period_start, m_run && (m_t == 0));
        for (int i = 0; i < CH; i++) begin
            if (out[i] ^ INV[i]) act_cnt[i]++;
            if (out[i]) raw_cnt[i]++;
        end
        if (period_start) ps_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < CH; i++) begin
            act_cnt[i] = 0;
            raw_cnt[i] = 0;
        end
        ps_cnt = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 80 && pending; k++) idle(1);
        check("commit_timeout", pending, 0);
    endtask

    task automatic align();
        for (int k = 0; k < 80 && !period_start; k++) idle(1);
        check("align", period_start, 1);
    endtask

    task automatic count_pending();
        n_pend = 0;
        for (int k = 0; k < 80 && pending; k++) begin
            n_pend++;
            idle(1);
        end
    endtask

    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_out", out, INV);
        check("rst_pending", pending, 0);
        check("rst_period_start", period_start, 0);
        check("rst_wr_ready", wr_ready, 1);
        model_reset();
        wr_valid = 1'b0;
        commit   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_valid = 1'b0; wr_chan = '0; wr_level = '0; mode_in = 1'b0; commit = 1'b0;
        model_reset();
        clear_counts();
        repeat (3) @(negedge clk);
        check("reset_out", out, INV);
        check("reset_pending", pending, 0);
        check("reset_period_start", period_start, 0);
        reset_n = 1'b1;
        idle(3);

        // Edge mode, levels 0/5/16.
        step(1'b1, 2'd0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 5'd5, 1'b0, 1'b0);
        step(1'b1, 2'd2, 5'd16, 1'b0, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0, 1'b1);
        wait_idle();
        idle(2);
        clear_counts();
        idle(N);
        check("edge_ch0_duty", act_cnt[0], 0);
        check("edge_ch1_duty", act_cnt[1], 5);
        check("edge_ch2_duty", act_cnt[2], 16);
        check("edge_ps_count", ps_cnt, 1);

        // Write level 8 then commit at counter 2: pending until the boundary.
        align();
        idle(1);
        step(1'b1, 2'd1, 5'd8, 1'b0, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0, 1'b1);
        count_pending();
        check("mid_commit_pending_cycles", n_pend, N - 3);
        idle(2);
        clear_counts();
        idle(N);
        check("new_ch1_duty", act_cnt[1], 8);

        // Commit in the last cycle of a period defers by one full period.
        align();
        for (int k = 0; k < 40 && m_t != N - 1; k++) idle(1);
        step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        count_pending();
        check("late_commit_pending_cycles", n_pend, N);

        // Center mode, level 3 on every channel.
        for (int i = 0; i < CH; i++) step(1'b1, 2'(i), 5'd3, 1'b0, 1'b0);
        step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        wait_idle();
        idle(2);
        clear_counts();
        idle(4 * N);
        check("center_ch0_duty", act_cnt[0], 12);
        check("center_ch1_duty", act_cnt[1], 12);
        check("center_ps_count", ps_cnt, 2);

        // Inverted twin: ch0 and ch1 share level 7 in edge mode.
        step(1'b1, 2'd0, 5'd7, 1'b0, 1'b0);
        step(1'b1, 2'd1, 5'd7, 1'b0, 1'b0);
        step(1'b1, 2'd3, 5'd2, 1'b0, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0, 1'b1);
        wait_idle();
        idle(2);
        clear_counts();
        idle(N);
        check("twin_ch0_high", raw_cnt[0], 7);
        check("twin_ch1_high", raw_cnt[1], N - 7);

        // Asynchronous reset mid-period with a commit pending.
        step(1'b1, 2'd2, 5'd9, 1'b0, 1'b0);
        step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        idle(3);
        async_reset();
        idle(3);
        clear_counts();
        idle(N);
        check("post_reset_ch0", act_cnt[0], 0);
        check("post_reset_ch1", act_cnt[1], 0);
        check("post_reset_ch2", act_cnt[2], 0);

        // Randomized traffic.
        for (int k = 0; k < 900; k++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 20)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 3, number of independent PWM outputs.
REQ-002 Parameter WIDTH, default 8, counter resolution in bits.
REQ-003 Parameter INVERT, default 0 (CHANNELS bits), per-channel polarity; bit i = 1 makes out[i] active low.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 wr_valid  input  1  level-write request.
REQ-007 wr_ready  output  1  level write accepted when wr_valid and wr_ready are both high on a clock edge.
REQ-008 wr_chan  input  clog2(CHANNELS), min 1  target channel of the write.
REQ-009 wr_level  input  WIDTH+1  duty level for the target channel.
REQ-010 mode_in  input  1  staged counting mode: 0 = edge-aligned, 1 = center-aligned.
REQ-011 commit  input  1  single-cycle request to apply staged levels and mode at the next period boundary.
REQ-012 pending  output  1  high from an accepted commit until its transfer completes.
REQ-013 period_start  output  1  one-cycle pulse in the first cycle of every period.
REQ-014 out  output  CHANNELS  PWM outputs.

Function
REQ-015 Each channel has a shadow level and an active level; the mode has shadow and active copies; comparisons use active copies only.
REQ-016 A write with wr_chan >= CHANNELS is accepted and discarded.
REQ-017 A write updates the shadow level only; wr_ready = !pending.
REQ-018 commit while pending = 0 sets pending on the next edge; commit while pending = 1 is ignored.
REQ-019 Shadow mode is sampled from mode_in in the cycle commit is accepted.
REQ-020 Edge mode: counter counts 0 to 2^WIDTH-1 and wraps; period = 2^WIDTH cycles; the last cycle has counter = 2^WIDTH-1.
REQ-021 Center mode: counter counts up 0 to 2^WIDTH-1, then down 2^WIDTH-1 to 0, so each endpoint is held 2 cycles; period = 2^(WIDTH+1) cycles; the last cycle is the down-phase cycle with counter = 0.
REQ-022 Raw compare: on[i] = (counter < active_level[i]), with both operands zero-extended to WIDTH+1 bits.
REQ-023 Consequences of REQ-022: level 0 is never on; level >= 2^WIDTH is always on (100%); edge-mode on-time = level cycles; center-mode on-time = 2*level cycles, symmetric about the period midpoint.
REQ-024 out[i] = on[i] XOR INVERT[i].
REQ-025 out is registered: it reflects the counter value of the previous cycle, giving a fixed 1-cycle latency.
REQ-026 If pending = 1 in the last cycle of a period, then on that edge: all shadow levels and the shadow mode copy to active; pending clears; counter becomes 0 in the up phase.
REQ-027 A commit accepted in the last cycle of a period is not applied on that boundary; it applies on the following boundary.
REQ-028 period_start is high when the counter is 0 in the first cycle of a period (up phase in center mode); it is not registered behind out.
REQ-029 The new mode's first period starts immediately after the transfer, with no partial period.

Reset
REQ-030 While reset_n = 0: counter = 0, phase = up, all shadow and active levels = 0, both mode copies = 0, pending = 0, period_start = 0, out[i] = INVERT[i] (inactive level).
REQ-031 Assertion of reset_n takes effect immediately, including mid-period and while pending = 1; any staged writes are lost.
REQ-032 The first period starts on the first clock edge after reset_n deasserts; period_start pulses in that cycle.

Structure
REQ-033 A shared package holds the mode encoding constants MODE_EDGE and MODE_CENTER.
REQ-034 The up/down counter, phase register and boundary/period_start decode live in one sub-module, pwm_timebase; the per-channel compare is generated inline in pwm_bank.

Verification
REQ-035 WIDTH=4, CHANNELS=3, edge mode, levels 0/5/16 committed -> after the boundary, ch0 is never high, ch1 is high for 5 of 16 cycles, ch2 is constantly high.
REQ-036 Center mode, WIDTH=4, level 3 -> out high for 3 cycles at each end of the 32-cycle period (6 of 32 total), period_start every 32 cycles.
REQ-037 Write level 8, commit at counter = 2 -> pending stays high and wr_ready stays low until the boundary; out keeps the old duty until then and switches in the next period.
REQ-038 commit asserted in the last cycle of a period -> no transfer at that boundary; pending clears exactly one period later.
REQ-039 INVERT=3'b010 -> ch1 is high during reset and the complement of a non-inverted twin channel with the same level.
REQ-040 reset_n pulsed low mid-period with pending = 1 -> outputs are at inactive level asynchronously, pending = 0, and all levels read back as 0 behaviour after release.
